uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_if.sv | 27 ++
 rtl/uart_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// Byte-stream loader bus: UART receive side in, memory write port and status out.
// The master drives the receive stream and start; the loader is the slave.
interface uart_loader_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, rx_data, rx_valid, rx_ferr,
    input  mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded
  );

  modport slave (
    input  start, rx_data, rx_valid, rx_ferr,
    output mem_we, mem_addr, mem_wdata, busy, done, err, words_loaded
  );
endinterface

// File: rtl/uart_loader.sv
// UART memory loader: 32-bit little-endian word count, then N words written to memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module uart_loader #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic        clk,
  input logic        rstn,
  uart_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byteIdx;
  logic [23:0]       r_shift;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_words;
  logic              r_ferrQ;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memWdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic [31:0]       w_word;
  logic              w_ferrRise;
  logic              w_lastByte;
  logic              w_tooBig;
  logic [ADDR_W:0]   w_nextWords;
  logic [ADDR_W-1:0] w_addr;

  // Each new byte enters at the top and older bytes shift down, so byte 0 ends in [7:0].
  assign w_word      = {bus.rx_data, r_shift};
  assign w_ferrRise  = bus.rx_ferr & ~r_ferrQ;
  assign w_lastByte  = (r_byteIdx == 2'd3);
  assign w_tooBig    = ({1'b0, w_word} > (33'd1 << ADDR_W));
  assign w_nextWords = r_words + (ADDR_W+1)'(1);
  assign w_addr      = BASE_ADDR + r_words[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_byteIdx  <= 2'd0;
      r_shift    <= 24'd0;
      r_count    <= '0;
      r_words    <= '0;
      r_ferrQ    <= 1'b1;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      r_ferrQ <= bus.rx_ferr;
      r_memWe <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_state   <= S_HDR;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_words   <= '0;
            r_byteIdx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
          end
        end
        default: begin
          // A fresh framing error beats any byte arriving in the same cycle.
          if (w_ferrRise) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (bus.rx_valid) begin
            r_shift   <= w_word[31:8];
            r_byteIdx <= r_byteIdx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            if (r_state != S_CSUM) begin
              r_csum <= r_csum ^ bus.rx_data;
            end
`endif
            case (r_state)
              S_HDR: begin
                if (w_lastByte) begin
                  r_count <= w_word[ADDR_W:0];
                  if (w_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                    r_state <= S_CSUM;
`else
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
`endif
                  end else if (w_tooBig) begin
                    r_state <= S_ERR;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b1;
                  end else begin
                    r_state <= S_DATA;
                  end
                end
              end
              S_DATA: begin
                if (w_lastByte) begin
                  r_memWe    <= 1'b1;
                  r_memAddr  <= w_addr;
                  r_memWdata <= w_word;
                  r_words    <= w_nextWords;
                  if (w_nextWords == r_count) begin
`ifdef LOADER_CHECKSUM_EN
                    r_state <= S_CSUM;
`else
                    r_state <= S_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
`endif
                  end
                end
              end
`ifdef LOADER_CHECKSUM_EN
              S_CSUM: begin
                r_busy <= 1'b0;
                if (bus.rx_data == r_csum) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                end
              end
`endif
              default: begin
                r_state <= r_state;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.mem_we       = r_memWe;
  assign bus.mem_addr     = r_memAddr;
  assign bus.mem_wdata    = r_memWdata;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: default-size loader plus a 4-bit-address copy for wrap.
// Checksum bytes are only sent when LOADER_CHECKSUM_EN is defined.
module tb_uart_loader;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       rxValid;
  logic       rxFerr;
  logic [7:0] rxData;

  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_W(14)) bus0 ();
  uart_loader_if #(.ADDR_W(4))  bus1 ();

  assign bus0.start    = start;
  assign bus0.rx_data  = rxData;
  assign bus0.rx_valid = rxValid;
  assign bus0.rx_ferr  = rxFerr;
  assign bus1.start    = start;
  assign bus1.rx_data  = rxData;
  assign bus1.rx_valid = rxValid;
  assign bus1.rx_ferr  = rxFerr;

  uart_loader #(.ADDR_W(14), .BASE_ADDR(14'd0)) dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
  uart_loader #(.ADDR_W(4),  .BASE_ADDR(4'd15)) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  int          wrAddr0[$];
  logic [31:0] wrData0[$];
  int          wrAddr1[$];

  // mem_we lasts one full cycle, so each write is seen by exactly one falling edge.
  always @(negedge clk) begin
    if (bus0.mem_we === 1'b1) begin
      wrAddr0.push_back(int'(bus0.mem_addr));
      wrData0.push_back(bus0.mem_wdata);
    end
    if (bus1.mem_we === 1'b1) begin
      wrAddr1.push_back(int'(bus1.mem_addr));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    applyStimulus(w[23:16]);
    applyStimulus(w[31:24]);
  endtask

  task automatic sendCsum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(c);
`else
    c = c;
`endif
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearLogs();
    wrAddr0.delete();
    wrData0.delete();
    wrAddr1.delete();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " mem_we"}, bus0.mem_we, 0);
    checkOutput({tag, " mem_addr"}, bus0.mem_addr, 0);
    checkOutput({tag, " mem_wdata"}, bus0.mem_wdata, 0);
    checkOutput({tag, " busy"}, bus0.busy, 0);
    checkOutput({tag, " done"}, bus0.done, 0);
    checkOutput({tag, " err"}, bus0.err, 0);
    checkOutput({tag, " words"}, bus0.words_loaded, 0);
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 1'b0;
    rxValid = 1'b0;
    rxFerr  = 1'b0;
    rxData  = 8'h00;
    idle(3);
    checkReset("reset");
    rstn = 1'b1;
    idle(2);

    $display("[TB] two-word load");
    clearLogs();
    pulseStart();
    checkOutput("load2 busy", bus0.busy, 1);
    sendWord(32'h0000_0002);
    sendWord(32'h1234_5678);
    sendWord(32'hDEAD_BEEF);
    sendCsum(8'h28);
    idle(2);
    checkOutput("load2 writes", wrAddr0.size(), 2);
    if (wrAddr0.size() >= 2) begin
      checkOutput("load2 addr0", wrAddr0[0], 0);
      checkOutput("load2 data0", wrData0[0], 32'h1234_5678);
      checkOutput("load2 addr1", wrAddr0[1], 1);
      checkOutput("load2 data1", wrData0[1], 32'hDEAD_BEEF);
    end
    checkOutput("load2 done", bus0.done, 1);
    checkOutput("load2 err", bus0.err, 0);
    checkOutput("load2 busy end", bus0.busy, 0);
    checkOutput("load2 words", bus0.words_loaded, 2);

    $display("[TB] bytes while done");
    sendWord(32'h5555_5555);
    idle(2);
    checkOutput("idle rx writes", wrAddr0.size(), 2);
    checkOutput("idle rx words", bus0.words_loaded, 2);
    checkOutput("idle rx done", bus0.done, 1);

    $display("[TB] zero-length load");
    clearLogs();
    pulseStart();
    checkOutput("zero done cleared", bus0.done, 0);
    checkOutput("zero words cleared", bus0.words_loaded, 0);
    sendWord(32'h0000_0000);
    sendCsum(8'h00);
    idle(2);
    checkOutput("zero writes", wrAddr0.size(), 0);
    checkOutput("zero done", bus0.done, 1);

    $display("[TB] start while busy");
    clearLogs();
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    sendWord(32'h0403_0201);
    sendCsum(8'h05);
    idle(2);
    checkOutput("restart writes", wrAddr0.size(), 1);
    if (wrAddr0.size() >= 1) begin
      checkOutput("restart data", wrData0[0], 32'h0403_0201);
    end
    checkOutput("restart done", bus0.done, 1);

    $display("[TB] framing error mid-word");
    clearLogs();
    pulseStart();
    sendWord(32'h0000_0001);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    @(negedge clk);
    rxData  = 8'h33;
    rxValid = 1'b1;
    rxFerr  = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    applyStimulus(8'h44);
    idle(2);
    checkOutput("ferr writes", wrAddr0.size(), 0);
    checkOutput("ferr err", bus0.err, 1);
    checkOutput("ferr done", bus0.done, 0);
    checkOutput("ferr busy", bus0.busy, 0);

    pulseStart();
    checkOutput("ferr restart err cleared", bus0.err, 0);
    sendWord(32'h0000_0001);
    sendWord(32'h4433_2211);
    sendCsum(8'h45);
    idle(2);
    checkOutput("ferr-high writes", wrAddr0.size(), 1);
    if (wrAddr0.size() >= 1) begin
      checkOutput("ferr-high data", wrData0[0], 32'h4433_2211);
    end
    checkOutput("ferr-high done", bus0.done, 1);
    checkOutput("ferr-high err", bus0.err, 0);
    rxFerr = 1'b0;
    idle(2);

    $display("[TB] address wrap on small loader");
    clearLogs();
    pulseStart();
    sendWord(32'h0000_0002);
    sendWord(32'h0403_0201);
    sendWord(32'h0807_0605);
    sendCsum(8'h0A);
    idle(2);
    checkOutput("wrap writes", wrAddr1.size(), 2);
    if (wrAddr1.size() >= 2) begin
      checkOutput("wrap addr0", wrAddr1[0], 15);
      checkOutput("wrap addr1", wrAddr1[1], 0);
    end
    checkOutput("wrap done", bus1.done, 1);
    checkOutput("wrap words", bus1.words_loaded, 2);

    $display("[TB] oversize header");
    clearLogs();
    pulseStart();
    sendWord(32'h0000_4001);
    idle(2);
    checkOutput("oversize err", bus0.err, 1);
    checkOutput("oversize busy", bus0.busy, 0);

    $display("[TB] max header then reset mid-load");
    pulseStart();
    sendWord(32'h0000_4000);
    idle(1);
    checkOutput("max hdr err", bus0.err, 0);
    checkOutput("max hdr busy", bus0.busy, 1);
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    #2 rstn = 1'b0;
    #3 checkReset("async reset");
    idle(1);
    rstn = 1'b1;
    applyStimulus(8'hA3);
    applyStimulus(8'hA4);
    sendWord(32'h0BAD_F00D);
    idle(2);
    checkOutput("post reset writes", wrAddr0.size(), 0);
    checkReset("post reset");

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] checksum good and bad");
    clearLogs();
    pulseStart();
    sendWord(32'h0000_0001);
    sendWord(32'hDDCC_BBAA);
    idle(1);
    checkOutput("csum wait busy", bus0.busy, 1);
    applyStimulus(8'h01);
    idle(2);
    checkOutput("csum good done", bus0.done, 1);
    checkOutput("csum good err", bus0.err, 0);
    clearLogs();
    pulseStart();
    sendWord(32'h0000_0001);
    sendWord(32'hDDCC_BBAA);
    applyStimulus(8'h00);
    idle(2);
    checkOutput("csum bad err", bus0.err, 1);
    checkOutput("csum bad done", bus0.done, 0);
    checkOutput("csum bad writes", wrAddr0.size(), 1);
    if (wrData0.size() >= 1) begin
      checkOutput("csum bad data", wrData0[0], 32'hDDCC_BBAA);
    end
`endif

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
